// File: rtl/seq_detector.sv
// Serial 10110 pattern detector (Mealy FSM) with a registered hit pulse,
// a saturating hit counter and a 5-bit sampled-bit history for the LEDs.
module seq_detector #(
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_cnt,
  output logic             cnt_sat,
  output logic [2:0]       state,
  output logic [4:0]       Led
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S2   = 3'd2;
  localparam logic [2:0] S3   = 3'd3;
  localparam logic [2:0] S4   = 3'd4;
  localparam logic [2:0] RESUME = (OVERLAP != 0) ? S2 : IDLE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       led_q, led_d;
  logic             pulse_q, pulse_d;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

  // Unencoded states (5..7) fall back to IDLE on the next sampled bit.
  always_comb begin
    state_d = state_q;
    if (bit_vld) begin
      case (state_q)
        IDLE:    state_d = bit_in ? S1 : IDLE;
        S1:      state_d = bit_in ? S1 : S2;
        S2:      state_d = bit_in ? S3 : IDLE;
        S3:      state_d = bit_in ? S4 : S2;
        S4:      state_d = bit_in ? S1 : RESUME;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit     = bit_vld && (state_q == S4) && !bit_in;
    pulse_d = hit;
    cnt_d   = cnt_q;
    if (hit && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
    led_d   = bit_vld ? {led_q[3:0], bit_in} : led_q;
  end

  assign det_pulse = pulse_q;
  assign det_cnt   = cnt_q;
  assign cnt_sat   = &cnt_q;
  assign state     = state_q;
  assign Led       = led_q;

endmodule
